// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//   Byte FIFO plus a small feeder FSM that sits directly in front of the UART
//   transmitter. The host writes bytes at any rate. The FSM pops them one at a
//   time and hands each one to the transmitter with a single-cycle TxStart. It
//   then waits for the transmitter's TxReady pulse before it issues the next
//   byte.
//
// Ports
//   Clock, ResetN      system clock; asynchronous active-low reset
//   WrEn, WrData       host write strobe and byte (dropped when Full)
//   Clear              synchronous flush of the FIFO (FSM is not aborted)
//   Full, Empty, Count FIFO occupancy status
//   Overflow           1-cycle pulse after a write was dropped because Full
//   Busy               FSM owns a byte (not IDLE)
//   TxStart, TxData    start pulse and byte for the transmitter
//   TxReady            end-of-frame pulse from the transmitter
module uart_tx_buffer #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16,
   parameter int ADDR_BITS = $clog2(DEPTH)
) (
   input  logic                 Clock,
   input  logic                 ResetN,
   input  logic                 WrEn,
   input  logic [DATA_BITS-1:0] WrData,
   input  logic                 Clear,
   output logic                 Full,
   output logic                 Empty,
   output logic [ADDR_BITS:0]   Count,
   output logic                 Overflow,
   output logic                 Busy,
   output logic                 TxStart,
   output logic [DATA_BITS-1:0] TxData,
   input  logic                 TxReady
);

   localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]     count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
   logic [DATA_BITS-1:0]   mem_q [DEPTH];

   logic full, empty, push, pop;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   // Full is the registered value, so a pop in the same cycle does not make
   // room for this write.
   assign push  = WrEn && !full && !Clear;
   assign pop   = (state_q == S_IDLE) && !empty;

   // Storage has no reset; its contents are meaningless while Count is 0.
   always_ff @(posedge Clock) begin
      if (push) mem_q[wr_ptr_q] <= WrData;
   end

   // ---------------- FIFO bookkeeping ----------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = 1'b0;
      tx_data_d  = tx_data_q;
      if (pop) tx_data_d = mem_q[rd_ptr_q];
      if (Clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         overflow_d = WrEn && full;
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_d = count_q + CNT_ONE;
         else if (pop && !push) count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // ---------------- feeder FSM ----------------
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!empty) state_d = S_START;
         S_START: state_d = S_WAIT;
         S_WAIT:  if (TxReady) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // TxStart decodes the state register directly, so the pulse is glitch-free
   // and lasts exactly one cycle.
   always_comb begin
      Busy    = (state_q != S_IDLE);
      TxStart = (state_q == S_START);
   end

   assign TxData   = tx_data_q;
   assign Count    = count_q;
   assign Full     = full;
   assign Empty    = empty;
   assign Overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

   localparam int DB    = 8;
   localparam int DEPTH = 16;

   logic          Clock = 1'b0;
   logic          ResetN = 1'b0;
   logic          WrEn = 1'b0;
   logic [DB-1:0] WrData = '0;
   logic          Clear = 1'b0;
   logic          Full, Empty, Overflow, Busy, TxStart;
   logic [4:0]    Count;
   logic [DB-1:0] TxData;
   logic          TxReady = 1'b0;

   uart_tx_buffer dut (
      .Clock(Clock), .ResetN(ResetN), .WrEn(WrEn), .WrData(WrData),
      .Clear(Clear), .Full(Full), .Empty(Empty), .Count(Count),
      .Overflow(Overflow), .Busy(Busy), .TxStart(TxStart), .TxData(TxData),
      .TxReady(TxReady)
   );

   always #10 Clock = ~Clock;

   int n_cmp = 0;
   int n_err = 0;
   int ov_seen;

   // Reference model: a queue of pending bytes, the byte owned by the
   // transmitter, and how far that hand-off has progressed
   // (0 = nothing owned, 1 = start cycle, 2 = awaiting end of frame).
   logic [DB-1:0] q[$];
   logic [DB-1:0] m_data;
   int            m_phase;
   logic          m_ov;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_data  = '0;
      m_phase = 0;
      m_ov    = 1'b0;
   endtask

   task automatic check_outputs();
      chk("Count",    32'(Count),    32'(q.size()));
      chk("Empty",    32'(Empty),    32'(q.size() == 0));
      chk("Full",     32'(Full),     32'(q.size() == DEPTH));
      chk("Overflow", 32'(Overflow), 32'(m_ov));
      chk("Busy",     32'(Busy),     32'(m_phase != 0));
      chk("TxStart",  32'(TxStart),  32'(m_phase == 1));
      chk("TxData",   32'(TxData),   32'(m_data));
   endtask

   // One clock: drive inputs at the falling edge, compare the registered
   // outputs, then advance the model across the rising edge.
   task automatic step(input logic wr, input logic [DB-1:0] d, input logic clr, input logic rdy);
      bit was_full, was_empty, popped;
      @(negedge Clock);
      WrEn = wr; WrData = d; Clear = clr; TxReady = rdy;
      check_outputs();
      if (Overflow) ov_seen++;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      popped    = (m_phase == 0) && !was_empty;
      @(posedge Clock);
      if (popped) begin
         m_data = q[0];
         void'(q.pop_front());
      end
      if (clr) q.delete();
      else if (wr && !was_full) q.push_back(d);
      m_ov = wr && was_full && !clr;
      case (m_phase)
         0: m_phase = popped ? 1 : 0;
         1: m_phase = 2;
         default: m_phase = rdy ? 0 : 2;
      endcase
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge Clock);
      ResetN = 1'b0; WrEn = 1'b0; Clear = 1'b0; TxReady = 1'b0;
      #1;
      model_reset();
      chk("rst_TxStart",  32'(TxStart),  0);
      chk("rst_TxData",   32'(TxData),   0);
      chk("rst_Empty",    32'(Empty),    1);
      chk("rst_Full",     32'(Full),     0);
      chk("rst_Count",    32'(Count),    0);
      chk("rst_Overflow", 32'(Overflow), 0);
      chk("rst_Busy",     32'(Busy),     0);
      @(negedge Clock);
      ResetN = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();
      idle(3);

      // Single byte: start pulse two cycles after the write, then held in WAIT.
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      idle(5);
      step(1'b0, '0, 1'b0, 1'b1);
      idle(3);

      // Ordering: three back-to-back bytes, each released by a TxReady.
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      for (int b = 0; b < 3; b++) begin
         idle(4);
         step(1'b0, '0, 1'b0, 1'b1);
      end
      idle(3);

      // Overflow: transmitter holds one byte, then 17 writes; 8'h10 is dropped.
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      idle(2);
      ov_seen = 0;
      for (int i = 0; i <= 16; i++) step(1'b1, DB'(i), 1'b0, 1'b0);
      idle(2);
      chk("ovf_pulses", 32'(ov_seen), 1);
      // Pop and write together while Full: pop happens, write still dropped.
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      idle(2);
      // Drain everything.
      for (int i = 0; i < 20; i++) begin
         idle(2);
         step(1'b0, '0, 1'b0, 1'b1);
      end

      // Clear mid-frame: the in-flight byte finishes, nothing else starts.
      for (int i = 0; i < 5; i++) step(1'b1, DB'(8'h50 + i), 1'b0, 1'b0);
      idle(2);
      step(1'b1, 8'h99, 1'b1, 1'b0);
      idle(3);
      step(1'b0, '0, 1'b0, 1'b1);
      idle(4);

      // Randomised traffic with a mid-traffic reset.
      for (int i = 0; i < 3000; i++) begin
         int wp;
         wp = ((i / 300) % 2 == 0) ? 70 : 20;
         if (i == 1500) do_reset();
         step(1'($urandom_range(99) < wp), DB'($urandom),
              1'($urandom_range(59) == 0), 1'($urandom_range(5) == 0));
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
